xrv1_fetch_pcgen: RTL and testbench

// - Front-end PC generator and instruction fetch queue; consumes the branch unit's exec redirect (exec_b_pc_vld/exec_b_pc).
// - Issues sequential word fetches to instruction memory over req/gnt + in-order rvalid.
// - Tags in-flight requests with an epoch and drops stale responses after a redirect.
// - Buffers {pc, instr} pairs toward decode over a valid/ready handshake.

---
 rtl/xrv1_fetch_pcgen_if.sv | 25 ++
 rtl/xrv1_fetch_pcgen.sv | 157 +++++++++++++++
 tb/tb_xrv1_fetch_pcgen.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/xrv1_fetch_pcgen_if.sv
// Fetch front-end bundle: branch redirect, imem req/gnt/rvalid channel and decode handshake.
// master = fetch unit (drives imem request and decode entry), slave = environment.
interface xrv1_fetch_pcgen_if;
    logic        exec_b_pc_vld;
    logic [31:0] exec_b_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_vld;
    logic        if_rdy;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    modport master (
        input  exec_b_pc_vld, exec_b_pc, imem_gnt, imem_rvalid, imem_rdata, if_rdy,
        output imem_req, imem_addr, if_vld, if_pc, if_instr
    );

    modport slave (
        output exec_b_pc_vld, exec_b_pc, imem_gnt, imem_rvalid, imem_rdata, if_rdy,
        input  imem_req, imem_addr, if_vld, if_pc, if_instr
    );
endinterface

// File: rtl/xrv1_fetch_pcgen.sv
// PC generator and instruction fetch queue.
// Sequential word fetches over req/gnt with in-order rvalid; in-flight requests carry a 1-bit
// epoch so responses issued before a redirect are dropped. {pc, instr} pairs are buffered
// toward decode. Define XRV1_FETCH_PERF_EN to add saturating redirect/drop counters.
module xrv1_fetch_pcgen #(
    parameter logic [31:0] RESET_PC_P        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH_P      = 2,
    parameter int unsigned MAX_OUTSTANDING_P = 2
) (
    input logic                clk_i,
    input logic                rst_ni,
    xrv1_fetch_pcgen_if.master bus
`ifdef XRV1_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_redirect_cnt_o,
    output logic [31:0]        perf_drop_cnt_o
`endif
);
    localparam int unsigned PendAw = (MAX_OUTSTANDING_P > 1) ? $clog2(MAX_OUTSTANDING_P) : 1;
    localparam int unsigned PendCw = $clog2(MAX_OUTSTANDING_P) + 1;
    localparam int unsigned FifoAw = $clog2(FIFO_DEPTH_P);
    localparam int unsigned FifoCw = FifoAw + 1;
    localparam logic [PendCw-1:0] MaxOut = PendCw'(MAX_OUTSTANDING_P);

    logic [31:0]       pc_q;
    logic              epoch_q;
    logic [31:0]       pend_pc_q [MAX_OUTSTANDING_P];
    logic              pend_ep_q [MAX_OUTSTANDING_P];
    logic [PendAw-1:0] pend_rd_q, pend_wr_q;
    logic [PendCw-1:0] outst_cnt_q;
    logic [31:0]       fifo_pc_q    [FIFO_DEPTH_P];
    logic [31:0]       fifo_instr_q [FIFO_DEPTH_P];
    logic [FifoAw-1:0] fifo_rd_q, fifo_wr_q;
    logic [FifoCw-1:0] fifo_cnt_q;

    logic        redirect, req, grant, resp, keep, drop, if_vld, pop;
    logic [31:0] redirect_pc;
    logic        unused_pc_lsb;

    function automatic logic [PendAw-1:0] pend_inc(input logic [PendAw-1:0] p);
        if (MAX_OUTSTANDING_P > 1) return p + 1'b1;
        return '0;
    endfunction

    assign redirect      = bus.exec_b_pc_vld;
    assign redirect_pc   = {bus.exec_b_pc[31:2], 2'b00};
    assign unused_pc_lsb = ^bus.exec_b_pc[1:0];

    // Issue gating: stale in-flight requests still hold a FIFO credit, so no overflow is possible.
    always_comb begin
        req = rst_ni && !redirect && (outst_cnt_q < MaxOut) &&
              ((32'(outst_cnt_q) + 32'(fifo_cnt_q)) < FIFO_DEPTH_P);
        grant  = req && bus.imem_gnt;
        // A response with nothing pending is a protocol error and is ignored.
        resp   = bus.imem_rvalid && (outst_cnt_q != '0);
        keep   = resp && (pend_ep_q[pend_rd_q] == epoch_q) && !redirect;
        drop   = resp && !keep;
        if_vld = (fifo_cnt_q != '0) && !redirect;
        pop    = if_vld && bus.if_rdy;
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.if_vld    = if_vld;
    assign bus.if_pc     = fifo_pc_q[fifo_rd_q];
    assign bus.if_instr  = fifo_instr_q[fifo_rd_q];

    // Fetch PC and epoch: redirect wins, otherwise advance one word per grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= RESET_PC_P;
            epoch_q <= 1'b0;
        end else if (redirect) begin
            pc_q    <= redirect_pc;
            epoch_q <= ~epoch_q;
        end else if (grant) begin
            pc_q <= pc_q + 32'd4;
        end
    end

    // Pending queue of granted requests awaiting rvalid, in grant order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING_P); i++) begin
                pend_pc_q[i] <= '0;
                pend_ep_q[i] <= 1'b0;
            end
            pend_rd_q   <= '0;
            pend_wr_q   <= '0;
            outst_cnt_q <= '0;
        end else begin
            if (grant) begin
                pend_pc_q[pend_wr_q] <= pc_q;
                pend_ep_q[pend_wr_q] <= epoch_q;
                pend_wr_q            <= pend_inc(pend_wr_q);
            end
            if (resp) pend_rd_q <= pend_inc(pend_rd_q);
            if (grant && !resp) outst_cnt_q <= outst_cnt_q + 1'b1;
            else if (!grant && resp) outst_cnt_q <= outst_cnt_q - 1'b1;
            // Re-tag every in-flight entry with the outgoing epoch (never the new one), so a
            // second redirect toggling the epoch back cannot make an old entry match again.
            // Grant is masked on a redirect, so this never collides with a push.
            if (redirect) begin
                for (int i = 0; i < int'(MAX_OUTSTANDING_P); i++) pend_ep_q[i] <= epoch_q;
            end
        end
    end

    // Output FIFO toward decode; flushed on redirect.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FIFO_DEPTH_P); i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            fifo_cnt_q <= '0;
        end else if (redirect) begin
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (keep) begin
                fifo_pc_q[fifo_wr_q]    <= pend_pc_q[pend_rd_q];
                fifo_instr_q[fifo_wr_q] <= bus.imem_rdata;
                fifo_wr_q               <= fifo_wr_q + 1'b1;
            end
            if (pop) fifo_rd_q <= fifo_rd_q + 1'b1;
            if (keep && !pop) fifo_cnt_q <= fifo_cnt_q + 1'b1;
            else if (!keep && pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;
        end
    end

`ifdef XRV1_FETCH_PERF_EN
    // Saturating counts of redirects and dropped responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_redirect_cnt_o <= '0;
            perf_drop_cnt_o     <= '0;
        end else begin
            if (redirect && (perf_redirect_cnt_o != '1)) begin
                perf_redirect_cnt_o <= perf_redirect_cnt_o + 32'd1;
            end
            if (drop && (perf_drop_cnt_o != '1)) perf_drop_cnt_o <= perf_drop_cnt_o + 32'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

    // Memory must never answer more requests than were granted.
    a_rvalid_has_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.imem_rvalid |-> (outst_cnt_q != '0));

endmodule

// File: tb/tb_xrv1_fetch_pcgen.sv
// Bench for xrv1_fetch_pcgen: directed scenarios followed by random traffic, all checked
// against a transaction-level model (queue of in-flight fetches with a stale flag set on
// every redirect, and a queue of entries expected at decode).
module tb_xrv1_fetch_pcgen;
    localparam int unsigned Depth = 2;
    localparam int unsigned MaxO  = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        bit          stale;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xrv1_fetch_pcgen_if bus ();

`ifdef XRV1_FETCH_PERF_EN
    logic [31:0] perf_redirect_cnt, perf_drop_cnt;
`endif

    xrv1_fetch_pcgen #(
        .RESET_PC_P       (32'h0000_0000),
        .FIFO_DEPTH_P     (Depth),
        .MAX_OUTSTANDING_P(MaxO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
`ifdef XRV1_FETCH_PERF_EN
        ,
        .perf_redirect_cnt_o(perf_redirect_cnt),
        .perf_drop_cnt_o    (perf_drop_cnt)
`endif
    );

    pend_t       pend_q[$];
    ent_t        out_q[$];
    logic [31:0] m_pc;
    int          checks = 0;
    int          errors = 0;
    int          grants_seen = 0;
    bit          arm_first = 0;
    logic [31:0] first_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
    task automatic step(input bit gnt, input bit rv_want, input bit rdy, input bit redir,
                        input logic [31:0] tgt);
        bit    exp_req, exp_vld, rv;
        pend_t h;
        rv                = rv_want && (pend_q.size() > 0);
        bus.imem_gnt      = gnt;
        bus.imem_rvalid   = rv;
        bus.imem_rdata    = rv ? pend_q[0].data : 32'($urandom);
        bus.if_rdy        = rdy;
        bus.exec_b_pc_vld = redir;
        bus.exec_b_pc     = redir ? tgt : 32'($urandom);
        exp_req = !redir && (pend_q.size() < MaxO) && (pend_q.size() + out_q.size() < Depth);
        exp_vld = !redir && (out_q.size() > 0);
        @(negedge clk);
        chk("imem_req", bus.imem_req, exp_req);
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("if_vld", bus.if_vld, exp_vld);
        if (exp_vld) begin
            chk("if_pc", bus.if_pc, out_q[0].pc);
            chk("if_instr", bus.if_instr, out_q[0].instr);
        end
        if (bus.imem_req === 1'b1 && gnt) grants_seen++;
        if (arm_first && bus.if_vld === 1'b1) begin
            first_pc  = bus.if_pc;
            arm_first = 0;
        end
        @(posedge clk);
        if (exp_vld && rdy) void'(out_q.pop_front());
        if (rv) begin
            h = pend_q.pop_front();
            if (!h.stale && !redir) out_q.push_back('{h.pc, h.data});
        end
        if (exp_req && gnt) begin
            pend_q.push_back('{m_pc, 32'($urandom), 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            out_q.delete();
            m_pc = {tgt[31:2], 2'b00};
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (pend_q.size() > 0 || out_q.size() > 0); i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        end
    endtask

    initial begin
        bus.imem_gnt      = 1'b0;
        bus.imem_rvalid   = 1'b0;
        bus.imem_rdata    = '0;
        bus.if_rdy        = 1'b0;
        bus.exec_b_pc_vld = 1'b0;
        bus.exec_b_pc     = '0;
        m_pc              = 32'h0;
        first_pc          = 32'hDEAD_BEEF;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_req", bus.imem_req, 1'b0);
        chk("rst_vld", bus.if_vld, 1'b0);
        chk("rst_if_pc", bus.if_pc, 32'h0);
        chk("rst_if_instr", bus.if_instr, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Sequential fetch with 1-cycle responses and decode always ready.
        arm_first = 1;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("seq_first_pc", first_pc, 32'h0);
        drain();

        // Decode stalled: only two grants fit, then request stays low until a pop.
        grants_seen = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("stall_grants", grants_seen, 32'd2);
        chk("stall_req_low", bus.imem_req, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        drain();

        // Redirect to 0x103 with two requests pending.
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
        chk("redir_addr", bus.imem_addr, 32'h0000_0100);
        first_pc  = 32'hDEAD_BEEF;
        arm_first = 1;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_first_pc", first_pc, 32'h0000_0100);
        drain();

        // Two back-to-back redirects while old requests are still in flight.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
        first_pc  = 32'hDEAD_BEEF;
        arm_first = 1;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("dbl_redir_first_pc", first_pc, 32'h0000_0300);
        drain();

        // Redirect in the same cycle as rvalid and if_rdy.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0400);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        drain();

        // Address wrap at the top of memory.
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        chk("wrap_start", bus.imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("wrap_addr", bus.imem_addr, 32'h0000_0000);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        drain();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 10) < 7, ($urandom % 10) < 6, ($urandom % 10) < 7,
                 ($urandom % 20) == 0, 32'($urandom));
        end

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        bus.exec_b_pc_vld = 1'b0;
        bus.imem_rvalid   = 1'b0;
        bus.imem_gnt      = 1'b0;
        rst_n             = 1'b0;
        #2;
        chk("midrst_req", bus.imem_req, 1'b0);
        chk("midrst_vld", bus.if_vld, 1'b0);
        chk("midrst_addr", bus.imem_addr, 32'h0);
        chk("midrst_if_pc", bus.if_pc, 32'h0);
        chk("midrst_if_instr", bus.if_instr, 32'h0);
        pend_q.delete();
        out_q.delete();
        m_pc = 32'h0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
